// File: rtl/pe_grid_pkg.sv
// pe_grid_pkg: shared widths, drain FSM encoding and column-slice helper for the PE grid.
package pe_grid_pkg;

    localparam int DATA_W = 32;
    localparam int LANE_W = 9;

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} drain_state_e;

    // Column 0 occupies the MSBs of a row, so column j starts at this LSB.
    function automatic int col_lsb(input int cols, input int j);
        return (cols - j - 1) * DATA_W;
    endfunction

endpackage

// File: rtl/pe_grid_row_fifo.sv
// pe_grid_row_fifo: synchronous FIFO of whole result rows with registered count.
// Head row is read from storage only, so a row pushed this cycle is not visible until the next.
module pe_grid_row_fifo
    import pe_grid_pkg::*;
#(
    parameter int COLS  = 1,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [COLS*DATA_W-1:0] i_wdata,
    input  logic                   i_pop,
    output logic [COLS*DATA_W-1:0] o_rdata,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [COLS*DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]          r_wr_ptr;
    logic [AW-1:0]          r_rd_ptr;
    logic [AW:0]            r_count;
    logic                   w_wr;
    logic                   w_rd;

    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_empty = r_count == '0;
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;
    assign o_rdata = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(w_wr);
            r_rd_ptr <= r_rd_ptr + AW'(w_rd);
            r_count  <= r_count + (AW+1)'(w_wr) - (AW+1)'(w_rd);
        end
    end

endmodule

// File: rtl/pe_grid_result_drain.sv
// pe_grid_result_drain: buffers PE-grid result rows and serialises them onto a 32-bit valid/ready stream.
// Define PE_DRAIN_ACC_EN to sum ACC_LEN consecutive rows (K-tiling) before each row is enqueued.
module pe_grid_result_drain
    import pe_grid_pkg::*;
#(
    parameter int COLS    = 1,
    parameter int DEPTH   = 4,
    parameter int ACC_LEN = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_valid,
    input  logic [COLS*DATA_W-1:0] i_col_data,
    output logic                   o_full,
    output logic                   o_drop,
    output logic                   o_ovf,
    output logic [DATA_W-1:0]      o_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic                   o_last
);

    localparam int RW = COLS * DATA_W;
    localparam int KW = COLS > 1 ? $clog2(COLS) : 1;

    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_hs;
    logic          w_row_end;
    logic [RW-1:0] w_push_data;
    logic [RW-1:0] w_head;
    logic [RW-1:0] r_shift;
    logic [KW-1:0] r_k;
    logic          r_drop;
    drain_state_e  r_state;
    drain_state_e  w_state_nx;

`ifdef PE_DRAIN_ACC_EN
    localparam int CW = ACC_LEN > 1 ? $clog2(ACC_LEN) : 1;

    logic [CW-1:0]   r_cnt;
    logic [RW-1:0]   r_acc;
    logic [RW-1:0]   w_base;
    logic [COLS-1:0] w_ovf_col;
    logic            w_row_done;
    logic            r_ovf;

    assign w_base     = r_cnt == '0 ? '0 : r_acc;
    assign w_row_done = r_cnt == CW'(ACC_LEN - 1);
    assign w_push     = i_valid && w_row_done;
    assign o_ovf      = r_ovf;

    for (genvar j = 0; j < COLS; j++) begin : g_col
        localparam int L = col_lsb(COLS, j);
        logic [DATA_W-1:0] w_a;
        logic [DATA_W-1:0] w_b;
        logic [DATA_W-1:0] w_s;
        assign w_a = w_base[L +: DATA_W];
        assign w_b = i_col_data[L +: DATA_W];
        assign w_s = w_a + w_b;
        assign w_push_data[L +: DATA_W] = w_s;
        assign w_ovf_col[j] = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_s[DATA_W-1] != w_a[DATA_W-1]);
    end

    // The tile clears on its last row even if the FIFO drops the sum.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_valid) begin
            r_cnt <= w_row_done ? '0 : r_cnt + CW'(1);
            r_acc <= w_row_done ? '0 : w_push_data;
            r_ovf <= r_ovf | (|w_ovf_col);
        end
    end
`else
    assign w_push      = i_valid;
    assign w_push_data = i_col_data;
    assign o_ovf       = 1'b0;
`endif

    pe_grid_row_fifo #(
        .COLS  (COLS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_wdata (w_push_data),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (o_full),
        .o_empty (w_empty)
    );

    assign o_valid = r_state == EMIT;
    assign o_last  = r_state == EMIT && r_k == KW'(COLS - 1);
    assign o_data  = r_shift[col_lsb(COLS, 0) +: DATA_W];
    assign o_drop  = r_drop;

    // Reloading on the final handshake keeps back-to-back rows bubble-free.
    always_comb begin
        w_hs       = r_state == EMIT && i_ready;
        w_row_end  = w_hs && r_k == KW'(COLS - 1);
        w_pop      = !w_empty && (r_state == IDLE || w_row_end);
        w_state_nx = w_pop ? EMIT : (w_row_end ? IDLE : r_state);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_k     <= '0;
            r_drop  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_drop  <= r_drop | (w_push && o_full);
            if (w_pop) begin
                r_shift <= w_head;
                r_k     <= '0;
            end else if (w_hs) begin
                r_shift <= r_shift << DATA_W;
                r_k     <= r_k + KW'(1);
            end
        end
    end

endmodule

// File: tb/tb_pe_grid_result_drain.sv
// tb_pe_grid_result_drain: directed checks of the result drain (COLS=3, DEPTH=4).
// Inputs change 1ns after the rising edge; a negedge monitor scoreboards the stream when enabled.
`timescale 1ns/1ps
module tb_pe_grid_result_drain;

    localparam int COLS    = 3;
    localparam int DEPTH   = 4;
    localparam int ACC_LEN = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_valid = 1'b0;
    logic              i_ready = 1'b0;
    logic [COLS*32-1:0] col_data = '0;
    logic              o_full, o_drop, o_ovf, o_valid, o_last;
    logic [31:0]       o_data;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_w;
    bit          mon_en = 1'b0;
    bit          p_stall = 1'b0;
    logic [31:0] p_data;
    logic        p_last;

    always #5 clk = ~clk;

    pe_grid_result_drain #(
        .COLS    (COLS),
        .DEPTH   (DEPTH),
        .ACC_LEN (ACC_LEN)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_valid    (i_valid),
        .i_col_data (col_data),
        .o_full     (o_full),
        .o_drop     (o_drop),
        .o_ovf      (o_ovf),
        .o_data     (o_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_last     (o_last)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_row(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input bit track);
        i_valid  = 1'b1;
        col_data = {a, b, c};
        if (track) begin
            exp_q.push_back({1'b0, a});
            exp_q.push_back({1'b0, b});
            exp_q.push_back({1'b1, c});
        end
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_left", 32'(exp_q.size()), 0);
        check("drain_idle", o_valid, 0);
    endtask

    // Stream scoreboard: stall stability plus in-order data/last against exp_q.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (p_stall) begin
                check("stall_valid", o_valid, 1);
                check("stall_data", o_data, p_data);
                check("stall_last", o_last, p_last);
            end
            if (o_valid && i_ready) begin
                check("mon_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    mon_w = exp_q.pop_front();
                    check("mon_data", o_data, mon_w[31:0]);
                    check("mon_last", o_last, mon_w[32]);
                end
            end
            p_stall = o_valid && !i_ready;
            p_data  = o_data;
            p_last  = o_last;
        end else begin
            p_stall = 1'b0;
        end
    end

    initial begin
        int accepted;
        int cyc;
        logic [31:0] a, b, c;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", o_valid, 0);
        check("rst_last", o_last, 0);
        check("rst_data", o_data, 0);
        check("rst_full", o_full, 0);
        check("rst_drop", o_drop, 0);
        check("rst_ovf", o_ovf, 0);
`ifdef PE_DRAIN_ACC_EN
        i_ready = 1'b1;
        push_row(32'd10, 32'd1, 32'hFFFF_FFFF, 1'b0);
        check("acc_hold1", o_valid, 0);
        push_row(32'd20, 32'd1, 32'hFFFF_FFFF, 1'b0);
        check("acc_hold2", o_valid, 0);
        push_row(32'd30, 32'd1, 32'hFFFF_FFFF, 1'b0);
        check("acc_hold3", o_valid, 0);
        push_row(32'd40, 32'd1, 32'hFFFF_FFFF, 1'b0);
        check("acc_lat", o_valid, 0);
        tick();
        check("acc_w0", o_data, 100);
        check("acc_l0", o_last, 0);
        tick();
        check("acc_w1", o_data, 4);
        tick();
        check("acc_w2", o_data, 32'hFFFF_FFFC);
        check("acc_l2", o_last, 1);
        check("acc_no_ovf", o_ovf, 0);
        push_row(32'h7FFF_FFFF, 32'd0, 32'd0, 1'b0);
        check("ovf_pre", o_ovf, 0);
        push_row(32'd1, 32'd0, 32'd0, 1'b0);
        check("ovf_set", o_ovf, 1);
        push_row(32'd0, 32'd0, 32'd0, 1'b0);
        push_row(32'd0, 32'd0, 32'd0, 1'b0);
        tick();
        check("ovf_w0", o_data, 32'h8000_0000);
        check("ovf_valid", o_valid, 1);
        tick();
        check("ovf_w1", o_data, 0);
        tick();
        check("ovf_l2", o_last, 1);
        check("ovf_sticky", o_ovf, 1);
`else
        // Single row, always ready: one idle cycle, then three consecutive words.
        i_ready = 1'b1;
        push_row(32'd1, 32'd2, 32'd3, 1'b0);
        check("t1_lat", o_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_valid", o_valid, 1);
            check("t1_data", o_data, i + 1);
            check("t1_last", o_last, i == 2);
        end
        tick();
        check("t1_end", o_valid, 0);
        // Head row sits in the shift register, so the FIFO fills on the fifth push.
        i_ready = 1'b0;
        for (int r = 1; r <= 6; r++) begin
            push_row(3*r-2, 3*r-1, 3*r, 1'b0);
            if (r == 4) check("t2_not_full", o_full, 0);
            if (r == 5) check("t2_full", o_full, 1);
            if (r == 5) check("t2_no_drop", o_drop, 0);
            if (r == 6) check("t2_drop", o_drop, 1);
        end
        i_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            check("t2_valid", o_valid, 1);
            check("t2_data", o_data, i + 1);
            check("t2_last", o_last, i % 3 == 2);
            tick();
        end
        check("t2_end", o_valid, 0);
        check("t2_sticky", o_drop, 1);
        // Reset after the first word of a row discards it and the queued row behind it.
        push_row(32'd7, 32'd8, 32'd9, 1'b0);
        push_row(32'd4, 32'd5, 32'd6, 1'b0);
        check("t4_w0", o_data, 7);
        tick();
        check("t4_w1", o_data, 8);
        rst = 1'b1;
        tick();
        check("t4_valid", o_valid, 0);
        check("t4_data", o_data, 0);
        check("t4_last", o_last, 0);
        check("t4_drop_clr", o_drop, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_empty", o_valid, 0);
        end
        mon_en = 1'b1;
        push_row(32'd11, 32'd12, 32'd13, 1'b1);
        wait_drain(20);
        // Push coincides with the pop at count DEPTH-1: accepted, nothing dropped.
        i_ready = 1'b0;
        for (int r = 0; r < 4; r++) push_row(32'h100 + r, 32'h200 + r, 32'h300 + r, 1'b1);
        check("t6_count3", o_full, 0);
        i_ready = 1'b1;
        tick();
        tick();
        push_row(32'hA1, 32'hA2, 32'hA3, 1'b1);
        check("t6_pp_full", o_full, 0);
        check("t6_pp_drop", o_drop, 0);
        wait_drain(50);
        // Push at count DEPTH with a pop in the same edge is still dropped.
        i_ready = 1'b0;
        for (int r = 0; r < 5; r++) push_row(32'h400 + r, 32'h500 + r, 32'h600 + r, 1'b1);
        check("t6_full", o_full, 1);
        check("t6_pre_drop", o_drop, 0);
        i_ready = 1'b1;
        tick();
        tick();
        push_row(32'hB1, 32'hB2, 32'hB3, 1'b0);
        check("t6_drop", o_drop, 1);
        check("t6_after_full", o_full, 0);
        wait_drain(50);
        // Random back-pressure over 100 rows.
        accepted = 0;
        cyc = 0;
        while (accepted < 100 && cyc < 5000) begin
            i_ready = $urandom_range(0, 3) != 0;
            if (!o_full && $urandom_range(0, 1) == 1) begin
                a = $urandom;
                b = $urandom;
                c = $urandom;
                i_valid  = 1'b1;
                col_data = {a, b, c};
                exp_q.push_back({1'b0, a});
                exp_q.push_back({1'b0, b});
                exp_q.push_back({1'b1, c});
                accepted++;
            end else begin
                i_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        check("t3_rows", accepted, 100);
        wait_drain(500);
        check("t3_ovf", o_ovf, 0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
